// File: rtl/iic_cfg_seq.sv
// Power-up register initialisation sequencer for the I2C byte driver.
// Walks a {addr, data} table, writes each entry, optionally reads it back and retries.
module iic_cfg_seq #(
  parameter int          CLK_FRE    = 50_000_000,
  parameter int          ADDR_BYTE  = 1,
  parameter int          LEN_WIDTH  = 3,
  parameter int          CFG_NUM    = 16,
  parameter logic [7:0]  DEVICE_ID  = 8'h78,
  parameter int          PWR_DLY_MS = 20,
  parameter int          VERIFY     = 1,
  parameter int          MAX_RETRY  = 3,
  parameter int          BUSY_TO    = 4096
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cfg_start,
  output logic [7:0]                cfg_index,
  input  logic [ADDR_BYTE*8+7:0]    cfg_data,
  output logic                      iic_pluse,
  output logic [7:0]                iic_device_id,
  output logic                      iic_w_r,
  output logic [LEN_WIDTH:0]        iic_byte_len,
  output logic [ADDR_BYTE*8-1:0]    iic_addr,
  output logic [7:0]                iic_data_in,
  input  logic                      iic_busy,
  input  logic                      iic_byte_over,
  input  logic [7:0]                iic_data_out,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic [7:0]                err_index
);

  localparam int AW     = ADDR_BYTE * 8;
  localparam int MS_DIV = CLK_FRE / 1000;
  localparam int MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int TO_W   = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam int RT_W   = $clog2(MAX_RETRY + 2);

  localparam logic [MS_W-1:0] MS_LAST   = MS_W'(MS_DIV - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(BUSY_TO - 1);
  localparam logic [RT_W-1:0] RT_MAX    = RT_W'(MAX_RETRY);
  localparam logic [15:0]     PWR_LAST  = 16'(PWR_DLY_MS);
  localparam logic [7:0]      IDX_LAST  = 8'(CFG_NUM - 1);

  localparam logic [3:0] S_PWR   = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_TRIG  = 4'd2;
  localparam logic [3:0] S_WBUSY = 4'd3;
  localparam logic [3:0] S_WIDLE = 4'd4;
  localparam logic [3:0] S_RTRIG = 4'd5;
  localparam logic [3:0] S_CHK   = 4'd6;
  localparam logic [3:0] S_DLY   = 4'd7;
  localparam logic [3:0] S_NEXT  = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;
  localparam logic [3:0] S_ERR   = 4'd10;

  logic [3:0]      state;
  logic [MS_W-1:0] ms_cnt;
  logic            ms_tick;
  logic [15:0]     dly_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [2:0]      pl_cnt;
  logic [RT_W-1:0] retry;
  logic            start_q;
  logic            start_rise;
  logic            is_dly_entry;
  logic            unused_ok;

  assign iic_device_id = DEVICE_ID;
  assign iic_byte_len  = (LEN_WIDTH+1)'(1);
  assign start_rise    = cfg_start & ~start_q;
  assign is_dly_entry  = (cfg_data[AW+7:8] == {AW{1'b1}});
  assign ms_tick       = (ms_cnt == MS_LAST);
  // Byte-done strobe is informational only; transfer completion is taken from busy.
  assign unused_ok     = iic_byte_over;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ms_cnt  <= '0;
      start_q <= 1'b0;
    end else begin
      ms_cnt  <= ms_tick ? '0 : ms_cnt + 1'b1;
      start_q <= cfg_start;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_PWR;
      cfg_index   <= '0;
      iic_pluse   <= 1'b0;
      iic_w_r     <= 1'b1;
      iic_addr    <= '0;
      iic_data_in <= '0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      err_index   <= '0;
      dly_cnt     <= '0;
      to_cnt      <= '0;
      pl_cnt      <= '0;
      retry       <= '0;
    end else begin
      case (state)
        S_PWR: begin
          if (dly_cnt == PWR_LAST) begin
            dly_cnt <= '0;
            state   <= S_LOAD;
          end else if (ms_tick) begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end

        // Index has been stable for this whole cycle, so the table output is settled.
        S_LOAD: begin
          iic_addr    <= cfg_data[AW+7:8];
          iic_data_in <= cfg_data[7:0];
          iic_w_r     <= 1'b1;
          dly_cnt     <= '0;
          pl_cnt      <= '0;
          state       <= is_dly_entry ? S_DLY : S_TRIG;
        end

        // Pulse is held 4 clocks so the driver's synchroniser and edge detect see it.
        S_TRIG, S_RTRIG: begin
          if (pl_cnt == 3'd0) begin
            if (!iic_busy) begin
              iic_pluse <= 1'b1;
              pl_cnt    <= 3'd1;
            end
          end else if (pl_cnt == 3'd4) begin
            iic_pluse <= 1'b0;
            pl_cnt    <= '0;
            to_cnt    <= '0;
            state     <= S_WBUSY;
          end else begin
            pl_cnt <= pl_cnt + 1'b1;
          end
        end

        S_WBUSY: begin
          if (iic_busy) begin
            state <= S_WIDLE;
          end else if (to_cnt == TO_LAST) begin
            cfg_err   <= 1'b1;
            err_index <= cfg_index;
            state     <= S_ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        // iic_w_r doubles as the read flag; it only changes once the driver is idle.
        S_WIDLE: begin
          if (!iic_busy) begin
            if (!iic_w_r) begin
              state <= S_CHK;
            end else if (VERIFY != 0) begin
              iic_w_r <= 1'b0;
              state   <= S_RTRIG;
            end else begin
              state <= S_NEXT;
            end
          end
        end

        S_CHK: begin
          if (iic_data_out == iic_data_in) begin
            state <= S_NEXT;
          end else if (retry < RT_MAX) begin
            retry   <= retry + 1'b1;
            iic_w_r <= 1'b1;
            state   <= S_TRIG;
          end else begin
            cfg_err   <= 1'b1;
            err_index <= cfg_index;
            state     <= S_ERR;
          end
        end

        S_DLY: begin
          if (dly_cnt == {8'h00, iic_data_in}) begin
            state <= S_NEXT;
          end else if (ms_tick) begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end

        S_NEXT: begin
          retry <= '0;
          if (cfg_index == IDX_LAST) begin
            cfg_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            cfg_index <= cfg_index + 1'b1;
            state     <= S_LOAD;
          end
        end

        // Restart skips the power delay; the device is already powered.
        S_DONE, S_ERR: begin
          if (start_rise) begin
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_index <= '0;
            err_index <= '0;
            retry     <= '0;
            iic_w_r   <= 1'b1;
            state     <= S_LOAD;
          end
        end

        default: state <= S_PWR;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Directed bench for iic_cfg_seq: driver model on the pluse/busy handshake,
// expected-transfer queue checked by an independent pulse monitor.
module tb_iic_cfg_seq;

  localparam int BUSY_LEN = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_index;
  logic [15:0] cfg_data;
  logic        iic_pluse;
  logic [7:0]  iic_device_id;
  logic        iic_w_r;
  logic [3:0]  iic_byte_len;
  logic [7:0]  iic_addr;
  logic [7:0]  iic_data_in;
  logic        iic_busy;
  logic        iic_byte_over;
  logic [7:0]  iic_data_out;
  logic        cfg_done;
  logic        cfg_err;
  logic [7:0]  err_index;

  iic_cfg_seq #(
    .CLK_FRE(100_000), .ADDR_BYTE(1), .LEN_WIDTH(3), .CFG_NUM(3),
    .DEVICE_ID(8'h78), .PWR_DLY_MS(2), .VERIFY(1), .MAX_RETRY(3), .BUSY_TO(64)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_index(cfg_index),
    .cfg_data(cfg_data), .iic_pluse(iic_pluse), .iic_device_id(iic_device_id),
    .iic_w_r(iic_w_r), .iic_byte_len(iic_byte_len), .iic_addr(iic_addr),
    .iic_data_in(iic_data_in), .iic_busy(iic_busy), .iic_byte_over(iic_byte_over),
    .iic_data_out(iic_data_out), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .err_index(err_index)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] tbl [0:3];
  always_comb cfg_data = tbl[cfg_index[1:0]];

  logic [16:0] exp_q[$];

  // driver model state
  logic [7:0] mem [0:255];
  bit         no_busy = 1'b0;
  logic [7:0] bad_addr = 8'h00;
  int         bad_cnt = 0;
  int         pulse_cyc [0:63];
  int         fall_cyc [0:63];
  int         n_pulse = 0;
  int         n_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_entry(input logic [7:0] a, input logic [7:0] d, input int writes);
    for (int i = 0; i < writes; i++) begin
      exp_q.push_back({1'b1, a, d});
      exp_q.push_back({1'b0, a, d});
    end
  endtask

  task automatic push_table();
    push_entry(8'h10, 8'hA5, 1);
    push_entry(8'h11, 8'h5A, 1);
    push_entry(8'h12, 8'hFF, 1);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (!cfg_done && !cfg_err && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_done && !cfg_err) begin
      checks++;
      errors++;
      $display("FAIL %s: no done/err within %0d cycles", name, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pluse"}, iic_pluse, 1'b0);
    check({tag, "_w_r"}, iic_w_r, 1'b1);
    check({tag, "_index"}, cfg_index, 8'h00);
    check({tag, "_addr"}, iic_addr, 8'h00);
    check({tag, "_data"}, iic_data_in, 8'h00);
    check({tag, "_done"}, cfg_done, 1'b0);
    check({tag, "_err"}, cfg_err, 1'b0);
    check({tag, "_err_index"}, err_index, 8'h00);
    check({tag, "_dev_id"}, iic_device_id, 8'h78);
    check({tag, "_byte_len"}, iic_byte_len, 4'd1);
  endtask

  // driver model: busy rises 3 clocks after pluse and lasts BUSY_LEN clocks
  initial begin
    logic       prev;
    bit         act;
    int         cnt;
    logic       d_wr;
    logic [7:0] d_addr;
    logic [7:0] d_data;
    prev = 1'b0; act = 1'b0; cnt = 0;
    d_wr = 1'b1; d_addr = '0; d_data = '0;
    iic_busy = 1'b0; iic_byte_over = 1'b0; iic_data_out = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      iic_byte_over = 1'b0;
      if (!rstn) begin
        iic_busy = 1'b0;
        act = 1'b0;
        prev = 1'b0;
      end else begin
        if (iic_pluse && !prev && !act) begin
          act = 1'b1; cnt = 0;
          d_wr = iic_w_r; d_addr = iic_addr; d_data = iic_data_in;
          pulse_cyc[n_pulse % 64] = cyc;
          n_pulse++;
        end else if (act) begin
          cnt++;
          if (cnt == 3) begin
            if (no_busy) begin
              act = 1'b0;
            end else begin
              iic_busy = 1'b1;
              if (!d_wr) begin
                if (d_addr == bad_addr && bad_cnt > 0) begin
                  iic_data_out = 8'h00;
                  bad_cnt--;
                end else begin
                  iic_data_out = mem[d_addr];
                end
              end
            end
          end else if (cnt == 3 + BUSY_LEN) begin
            iic_busy = 1'b0;
            iic_byte_over = 1'b1;
            act = 1'b0;
            if (d_wr) mem[d_addr] = d_data;
            fall_cyc[n_fall % 64] = cyc;
            n_fall++;
            check("hold", {iic_w_r, iic_addr, iic_data_in}, {d_wr, d_addr, d_data});
          end
        end
        prev = iic_pluse;
      end
    end
  end

  // scoreboard monitor: every pluse rise must match the head of the expected queue
  initial begin
    logic        mprev;
    logic [16:0] e;
    mprev = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && iic_pluse && !mprev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got w_r=%0b addr=%0h data=%0h expected none",
                   iic_w_r, iic_addr, iic_data_in);
        end else begin
          e = exp_q.pop_front();
          check("pulse_fields", {iic_w_r, iic_addr, iic_data_in}, e);
        end
      end
      mprev = rstn ? iic_pluse : 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_cyc;
    int st_cyc;
    int err_cyc;
    int n;
    tbl[0] = 16'h10A5; tbl[1] = 16'h115A; tbl[2] = 16'h12FF; tbl[3] = 16'h0000;

    // asynchronous reset
    #2 rstn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);

    // plain verified sequence after power delay
    push_table();
    rstn = 1'b1;
    rel_cyc = cyc;
    wait_end("seq_basic", 3000);
    check("basic_done", cfg_done, 1'b1);
    check("basic_err", cfg_err, 1'b0);
    check("basic_pulses", n_pulse, 6);
    check("basic_queue", exp_q.size(), 0);
    check_range("basic_pwr_delay", pulse_cyc[0] - rel_cyc, 190, 320);

    // two bad reads on entry 1, then success
    n_pulse = 0; n_fall = 0;
    bad_addr = 8'h11; bad_cnt = 2;
    push_entry(8'h10, 8'hA5, 1);
    push_entry(8'h11, 8'h5A, 3);
    push_entry(8'h12, 8'hFF, 1);
    start_pulse();
    wait_end("seq_retry", 3000);
    check("retry_done", cfg_done, 1'b1);
    check("retry_err", cfg_err, 1'b0);
    check("retry_pulses", n_pulse, 10);
    check("retry_queue", exp_q.size(), 0);

    // entry 1 never reads back correctly
    n_pulse = 0; n_fall = 0;
    bad_cnt = 4;
    push_entry(8'h10, 8'hA5, 1);
    push_entry(8'h11, 8'h5A, 4);
    start_pulse();
    wait_end("seq_retry_fail", 3000);
    check("rfail_err", cfg_err, 1'b1);
    check("rfail_done", cfg_done, 1'b0);
    check("rfail_err_index", err_index, 8'h01);
    repeat (300) @(negedge clk);
    check("rfail_pulses", n_pulse, 10);
    check("rfail_queue", exp_q.size(), 0);
    check("rfail_pluse_low", iic_pluse, 1'b0);

    // delay entry of 5 ms between entries 0 and 2
    n_pulse = 0; n_fall = 0;
    bad_cnt = 0;
    tbl[1] = 16'hFF05;
    push_entry(8'h10, 8'hA5, 1);
    push_entry(8'h12, 8'hFF, 1);
    start_pulse();
    wait_end("seq_delay", 5000);
    check("delay_done", cfg_done, 1'b1);
    check("delay_pulses", n_pulse, 4);
    check("delay_queue", exp_q.size(), 0);
    check_range("delay_gap", pulse_cyc[2] - fall_cyc[1], 400, 600);

    // busy never rises: timeout, then restart without power delay
    n_pulse = 0; n_fall = 0;
    tbl[1] = 16'h115A;
    no_busy = 1'b1;
    exp_q.push_back({1'b1, 8'h10, 8'hA5});
    start_pulse();
    wait_end("seq_timeout", 3000);
    err_cyc = cyc;
    check("to_err", cfg_err, 1'b1);
    check("to_done", cfg_done, 1'b0);
    check("to_err_index", err_index, 8'h00);
    check_range("to_latency", err_cyc - pulse_cyc[0], 64, 80);
    check("to_queue", exp_q.size(), 0);
    no_busy = 1'b0;
    n_pulse = 0; n_fall = 0;
    push_table();
    st_cyc = cyc;
    start_pulse();
    wait_end("seq_restart", 3000);
    check("restart_done", cfg_done, 1'b1);
    check("restart_err", cfg_err, 1'b0);
    check_range("restart_latency", pulse_cyc[0] - st_cyc, 0, 20);
    check("restart_queue", exp_q.size(), 0);

    // reset during the read-back of entry 1
    n_pulse = 0; n_fall = 0;
    push_entry(8'h10, 8'hA5, 1);
    push_entry(8'h11, 8'h5A, 1);
    start_pulse();
    n = 0;
    while (!(n_fall >= 3 && iic_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(n_fall >= 3 && iic_busy)) begin
      checks++;
      errors++;
      $display("FAIL midreset_wait: read of entry 1 not seen within 2000 cycles");
    end
    repeat (2) @(negedge clk);
    check("pre_reset_w_r", iic_w_r, 1'b0);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    n_pulse = 0; n_fall = 0;
    push_table();
    rstn = 1'b1;
    rel_cyc = cyc;
    wait_end("seq_after_reset", 3000);
    check("after_reset_done", cfg_done, 1'b1);
    check("after_reset_pulses", n_pulse, 6);
    check("after_reset_queue", exp_q.size(), 0);
    check_range("after_reset_pwr_delay", pulse_cyc[0] - rel_cyc, 190, 320);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
